// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts one bubble per load-use pair and counts bubbles (saturating).
module id_ex_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [10:0]        id_ctrl,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [XLEN-1:0]    id_rs1_data,
   input  logic [XLEN-1:0]    id_rs2_data,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic [3:0]         id_funct,
   input  logic               id_use_rs1,
   input  logic               id_use_rs2,
   input  logic               flush,
   input  logic               hold,
   output logic [10:0]        ex_ctrl,
   output logic [XLEN-1:0]    ex_pc,
   output logic [XLEN-1:0]    ex_rs1_data,
   output logic [XLEN-1:0]    ex_rs2_data,
   output logic [XLEN-1:0]    ex_imm,
   output logic [RADDR_W-1:0] ex_rs1,
   output logic [RADDR_W-1:0] ex_rs2,
   output logic [RADDR_W-1:0] ex_rd,
   output logic [3:0]         ex_funct,
   output logic               ex_valid,
   output logic               clearcontrol,
   output logic               pc_write,
   output logic               ifid_write,
   output logic [CNT_W-1:0]   bubble_cnt
);

   // memread sits at bit 7 of the control bundle
   localparam int MEMREAD = 7;

   logic load_use;
   logic stall;
   logic bubble;
   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
      rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
      load_use = ex_valid && ex_ctrl[MEMREAD] &&
                 (ex_rd != '0) && (rs1_hit || rs2_hit);
      stall        = load_use && !flush;
      clearcontrol = stall;
      pc_write     = !stall && !hold;
      ifid_write   = !stall && !hold;
      bubble       = flush || (!hold && load_use);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_ctrl     <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_funct    <= '0;
         ex_valid    <= 1'b0;
         bubble_cnt  <= '0;
      end else begin
         if (bubble && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         if (flush) begin
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
            ex_valid    <= 1'b0;
         end else if (!hold) begin
            // a load-use bubble still captures the data fields
            ex_ctrl     <= load_use ? 11'd0 : id_ctrl;
            ex_valid    <= !load_use;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: model-driven scoreboard of the EX register
// and combinational stall outputs.
module tb_id_ex_stage;

   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int CW   = 2;
   localparam int OW   = 11 + 4*XLEN + 3*RW + 4 + 1 + CW;
   localparam logic [10:0] LW  = 11'h780;
   localparam logic [10:0] ADD = 11'h118;

   logic            clk = 1'b0;
   logic            rst;
   logic [10:0]     id_ctrl;
   logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [RW-1:0]   id_rs1, id_rs2, id_rd;
   logic [3:0]      id_funct;
   logic            id_use_rs1, id_use_rs2, flush, hold;
   logic [10:0]     ex_ctrl;
   logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [RW-1:0]   ex_rs1, ex_rs2, ex_rd;
   logic [3:0]      ex_funct;
   logic            ex_valid, clearcontrol, pc_write, ifid_write;
   logic [CW-1:0]   bubble_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .RADDR_W(RW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_ctrl(id_ctrl), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_funct(id_funct),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .flush(flush), .hold(hold),
      .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_valid(ex_valid),
      .clearcontrol(clearcontrol), .pc_write(pc_write),
      .ifid_write(ifid_write), .bubble_cnt(bubble_cnt)
   );

   logic [OW-1:0] obs;
   logic [2:0]    obs_comb;
   assign obs = {ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                 ex_rs1, ex_rs2, ex_rd, ex_funct, ex_valid, bubble_cnt};
   assign obs_comb = {clearcontrol, pc_write, ifid_write};

   // reference model state
   logic [10:0]     m_ctrl = '0;
   logic [XLEN-1:0] m_pc = '0, m_a = '0, m_b = '0, m_imm = '0;
   logic [RW-1:0]   m_rs1 = '0, m_rs2 = '0, m_rd = '0;
   logic [3:0]      m_funct = '0;
   logic            m_valid = 1'b0;
   logic [CW-1:0]   m_cnt = '0;

   logic [OW-1:0] sb[$];

   function automatic logic [OW-1:0] model_vec();
      return {m_ctrl, m_pc, m_a, m_b, m_imm, m_rs1, m_rs2, m_rd,
              m_funct, m_valid, m_cnt};
   endfunction

   function automatic logic model_lu();
      return m_valid && m_ctrl[7] && (m_rd != 0) &&
             ((id_use_rs1 && id_rs1 == m_rd) ||
              (id_use_rs2 && id_rs2 == m_rd));
   endfunction

   function automatic logic [2:0] exp_comb();
      logic st;
      st = model_lu() && !flush;
      return {st, !st && !hold, !st && !hold};
   endfunction

   task automatic rand_id();
      id_ctrl     = 11'($urandom);
      id_pc       = $urandom;
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      id_rs1      = RW'($urandom);
      id_rs2      = RW'($urandom);
      id_rd       = RW'($urandom);
      id_funct    = 4'($urandom);
      id_use_rs1  = 1'($urandom);
      id_use_rs2  = 1'($urandom);
   endtask

   task automatic set_id(input logic [10:0] c, input logic [RW-1:0] r1,
                         input logic [RW-1:0] r2, input logic [RW-1:0] rd,
                         input logic u1, input logic u2);
      rand_id();
      id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
      id_use_rs1 = u1; id_use_rs2 = u2;
   endtask

   // advance model and DUT one edge, queue the expected EX state
   task automatic tick();
      logic lu;
      lu = model_lu();
      if (rst) begin
         {m_ctrl, m_pc, m_a, m_b, m_imm, m_rs1, m_rs2, m_rd,
          m_funct, m_valid, m_cnt} = '0;
      end else begin
         if ((flush || (!hold && lu)) && m_cnt != '1) m_cnt = m_cnt + 1'b1;
         if (flush) begin
            {m_ctrl, m_pc, m_a, m_b, m_imm, m_rs1, m_rs2, m_rd,
             m_funct, m_valid} = '0;
         end else if (!hold) begin
            m_ctrl = lu ? 11'd0 : id_ctrl;
            m_valid = !lu;
            m_pc = id_pc; m_a = id_rs1_data; m_b = id_rs2_data;
            m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2;
            m_rd = id_rd; m_funct = id_funct;
         end
      end
      sb.push_back(model_vec());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [OW-1:0] e;
      rst = 1'b1; flush = 1'b0; hold = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rand_id();
         flush = 1'($urandom);
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs, e);
         end
      end
      rst = 1'b0; flush = 1'b0; hold = 1'b0;
      #1;
      checks++;
      if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
         errors++;
         $display("FAIL reset_pc_write got %b%b want 11", pc_write, ifid_write);
      end
   endtask

   task automatic test_pass();
      logic [OW-1:0] e;
      set_id(ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      id_pc = 32'h100; id_imm = 32'hFFFF_FFF0;
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e || ex_valid !== 1'b1 || ex_pc !== 32'h100 ||
          ex_imm !== 32'hFFFF_FFF0 || ex_ctrl !== 11'h118) begin
         errors++;
         $display("FAIL pass_through got %h want %h", obs, e);
      end
   endtask

   task automatic test_load_use();
      logic [OW-1:0] e;
      set_id(LW, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0);
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL lu_load got %h want %h", obs, e);
      end
      set_id(ADD, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1);
      #1;
      checks++;
      if (obs_comb !== exp_comb() || obs_comb !== 3'b100) begin
         errors++;
         $display("FAIL lu_stall got %b want %b", obs_comb, exp_comb());
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e || ex_valid !== 1'(i)) begin
            errors++;
            $display("FAIL lu_step%0d got %h want %h", i, obs, e);
         end
         checks++;
         if (obs_comb !== exp_comb()) begin
            errors++;
            $display("FAIL lu_release%0d got %b want %b", i, obs_comb, exp_comb());
         end
      end
   endtask

   task automatic test_no_stall();
      logic [OW-1:0] e;
      set_id(LW, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0);
      tick();
      e = sb.pop_front();
      set_id(ADD, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
      #1;
      checks++;
      if (obs !== e || obs_comb !== 3'b011) begin
         errors++;
         $display("FAIL nostall_x0 got %b want 011", obs_comb);
      end
      set_id(LW, 5'd1, 5'd1, 5'd7, 1'b1, 1'b0);
      tick();
      e = sb.pop_front();
      set_id(ADD, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0);
      #1;
      checks++;
      if (obs !== e || obs_comb !== 3'b011) begin
         errors++;
         $display("FAIL nostall_rs2 got %b want 011", obs_comb);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e || ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL nostall_load got %h want %h", obs, e);
      end
   endtask

   task automatic test_flush();
      logic [OW-1:0] e;
      set_id(LW, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0);
      tick();
      e = sb.pop_front();
      set_id(ADD, 5'd5, 5'd5, 5'd9, 1'b1, 1'b1);
      flush = 1'b1; hold = 1'b1;
      #1;
      checks++;
      if (obs_comb !== exp_comb() || clearcontrol !== 1'b0) begin
         errors++;
         $display("FAIL flush_comb got %b want %b", obs_comb, exp_comb());
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (obs !== e || ex_valid !== 1'b0 || ex_ctrl !== 11'd0) begin
         errors++;
         $display("FAIL flush_state got %h want %h", obs, e);
      end
      flush = 1'b0; hold = 1'b0;
   endtask

   task automatic test_hold();
      logic [OW-1:0] e, held;
      set_id(ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      tick();
      held = sb.pop_front();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_id();
         #1;
         checks++;
         if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
            errors++;
            $display("FAIL hold_pcw%0d got %b%b want 00", i, pc_write, ifid_write);
         end
         tick();
         e = sb.pop_front();
         checks++;
         if (obs !== e || obs !== held) begin
            errors++;
            $display("FAIL hold_keep%0d got %h want %h", i, obs, held);
         end
      end
      hold = 1'b0;
      flush = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rand_id();
         tick();
         e = sb.pop_front();
      end
      flush = 1'b0;
      checks++;
      if (obs !== e || bubble_cnt !== 2'd3) begin
         errors++;
         $display("FAIL saturate got %0d want 3", bubble_cnt);
      end
   endtask

   task automatic test_rst_mid_stall();
      logic [OW-1:0] e;
      set_id(LW, 5'd1, 5'd1, 5'd6, 1'b1, 1'b0);
      tick();
      e = sb.pop_front();
      set_id(ADD, 5'd2, 5'd6, 5'd9, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      checks++;
      if (pc_write !== 1'b0) begin
         errors++;
         $display("FAIL mid_stall_pre got %b want 0", pc_write);
      end
      tick();
      rst = 1'b0;
      e = sb.pop_front();
      #1;
      checks++;
      if (obs !== e || ex_valid !== 1'b0 || pc_write !== 1'b1) begin
         errors++;
         $display("FAIL mid_stall_rst got %h/%b want %h/1", obs, pc_write, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [OW-1:0] e;
      for (int i = 0; i < 40; i++) begin
         rand_id();
         if (i % 3 == 0) id_ctrl[7] = 1'b1;
         if (i % 3 == 1) begin
            id_rs1 = m_rd; id_use_rs1 = 1'b1;
         end
         flush = ($urandom_range(0, 7) == 0);
         hold  = ($urandom_range(0, 5) == 0);
         #1;
         checks++;
         if (obs_comb !== exp_comb()) begin
            errors++;
            $display("FAIL b2b_comb%0d got %b want %b", i, obs_comb, exp_comb());
         end
         tick();
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL b2b_empty%0d", i);
         end else begin
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
               errors++;
               $display("FAIL b2b_state%0d got %h want %h", i, obs, e);
            end
         end
      end
      flush = 1'b0; hold = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; hold = 1'b0;
      rand_id();
      #1;
      test_reset();
      test_pass();
      test_load_use();
      test_no_stall();
      test_flush();
      test_hold();
      test_rst_mid_stall();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
